posit_field_extract: RTL and testbench
======================================

Name: posit_field_extract

Overview:
- Pipelined posit decoder front end for the posit PPU.
- Splits one N-bit posit word (es = ES) into sign, signed regime value k, exponent bits and a left-aligned mantissa with hidden bit, and flags zero and NaR.
- Feeds the PPU arithmetic stages through one register stage.

Parameters:
- N, 32, posit word width (N ≥ 8).
- ES, 2, exponent field width.
- RS, $clog2(N), regime-count width; k is RS+1 bits signed.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- in_valid_i  in  1  In holds a valid posit this cycle.
- In  in  N  input posit word.
- out_valid_o  out  1  outputs below hold a decoded word.
- Sign  out  1  sign bit (In[N-1]).
- k  out  RS+1 (signed)  regime value.
- Exponent  out  ES  exponent field.
- Mantissa  out  N  hidden bit at bit N-1, fraction bits follow MSB-first, zero-padded at the LSBs.
- InRemain  out  N-1  magnitude bits: bits [N-2:0] of the two's complement of In if Sign=1, otherwise In[N-2:0].
- NaR  out  1  In == 1 followed by N-1 zeros.
- zero  out  1  In == 0.

Behaviour:
- Reset: synchronous; when rst_ni=0 at a clk_i rising edge, all outputs clear to 0, including out_valid_o.
- Latency: exactly 1 cycle.
- Handshake: at each rising edge with rst_ni=1, out_valid_o <= in_valid_i. When in_valid_i=1, all data outputs load the decode of In. When in_valid_i=0, data outputs hold their previous values. No backpressure.
- Decode (combinational, before the output register):
  - Sign = In[N-1].
  - Take the magnitude: mag = Sign ? −In : In. InRemain = mag[N-2:0].
  - Regime: r0 = InRemain[N-2]. Count the run length m of bits equal to r0, starting at bit N-2, with m in 1..N-1.
  - If r0=1 then k = m−1; else k = −m.
  - The terminating opposite bit, if present, is skipped.
  - Exponent = the next ES bits after the terminator, MSB-first. If fewer than ES bits remain, the missing low bits are 0.
  - Fraction = all bits after the exponent. Mantissa = {1, fraction, zeros} left-aligned to N bits.
  - Use a leading-zero/one counter plus a barrel left shift; no priority if-chains wider than N.
- Special cases:
  - zero: Sign=0, k=0, Exponent=0, Mantissa=0, InRemain=0, zero=1, NaR=0.
  - NaR: Sign=1, k=0, Exponent=0, Mantissa=0, InRemain=0, NaR=1, zero=0.
  - zero and NaR are never both 1.
- Run to end of word, with no terminator (e.g. 0x7FFFFFFF): k=N−2, Exponent=0, Mantissa=1 followed by zeros.
- Reset in the same cycle as in_valid_i=1: reset wins, and the input is dropped.
- Back-to-back valid inputs produce back-to-back valid outputs, one per cycle.

Test Plan:
1. Reset: hold rst_ni=0 for 2 cycles with in_valid_i=1 and In=0x40000000 -> all outputs 0, out_valid_o=0.
2. In=0x00000000, valid -> next cycle: zero=1, NaR=0, Sign=0, k=0, Exponent=00, Mantissa=0x00000000.
3. In=0x40000000 (one) -> Sign=0, k=0, Exponent=00, Mantissa=0x80000000, InRemain=0x40000000.
4. In=0xFFFFFFFF -> Sign=1, InRemain=0x00000001, k=−30 (6'b100010), Exponent=00, Mantissa=0x80000000.
5. In=0x68008840 -> Sign=0, k=1, Exponent=10, Mantissa=0x80110800. Then In=0x7FFFFFFF -> k=30, Exponent=00, Mantissa=0x80000000.
6. In=0x80000000 -> NaR=1, Sign=1, zero=0, k=0, Mantissa=0. Then drop in_valid_i -> out_valid_o=0 and data outputs hold.

Source files
------------

// File: rtl/posit_field_extract_if.sv
// Decode-stage bus: one posit word in, its split fields out one cycle later.
// The master side drives a word each cycle; the slave side is the decoder.
interface posit_field_extract_if #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int RS = $clog2(N)
) ();
    logic                in_valid_i;
    logic [N-1:0]        In;
    logic                out_valid_o;
    logic                Sign;
    logic signed [RS:0]  k;
    logic [ES-1:0]       Exponent;
    logic [N-1:0]        Mantissa;
    logic [N-2:0]        InRemain;
    logic                NaR;
    logic                zero;

    modport master (
        output in_valid_i, In,
        input  out_valid_o, Sign, k, Exponent, Mantissa, InRemain, NaR, zero
    );

    modport slave (
        input  in_valid_i, In,
        output out_valid_o, Sign, k, Exponent, Mantissa, InRemain, NaR, zero
    );
endinterface

// File: rtl/posit_field_extract.sv
// Posit decoder front end: splits a posit into sign, regime k, exponent and
// hidden-bit mantissa, registered once before the PPU arithmetic stages.
module posit_field_extract #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int RS = $clog2(N)
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    posit_field_extract_if.slave bus
);

    logic                sign_c;
    logic [N-2:0]        rem_c;
    logic [N-2:0]        run_x;
    logic                r0;
    logic [RS:0]         m;
    logic signed [RS:0]  k_c;
    logic [N-1:0]        shifted;
    logic [ES-1:0]       exp_c;
    logic [N-1:0]        mant_c;
    logic                is_zero;
    logic                is_nar;

    logic                valid_q;
    logic                sign_q;
    logic signed [RS:0]  k_q;
    logic [ES-1:0]       exp_q;
    logic [N-1:0]        mant_q;
    logic [N-2:0]        rem_q;
    logic                nar_q;
    logic                zero_q;

    always_comb begin
        sign_c  = bus.In[N-1];
        rem_c   = sign_c ? (N-1)'({N{1'b0}} - bus.In) : bus.In[N-2:0];
        r0      = rem_c[N-2];
        // Inverting a run of ones turns the regime into a leading-zero count.
        run_x   = r0 ? ~rem_c : rem_c;
        m       = (RS+1)'(N-1);
        for (int i = 0; i < N-1; i++) begin
            if (run_x[i]) begin
                m = (RS+1)'(N-2-i);
            end
        end
        k_c     = r0 ? signed'(m - (RS+1)'(1)) : -signed'(m);
        // Drop the regime run plus its terminator; the guard zero keeps N bits.
        shifted = {rem_c, 1'b0} << (m + (RS+1)'(1));
        exp_c   = shifted[N-1 -: ES];
        mant_c  = {1'b1, {(N-1){1'b0}}} | ((shifted << ES) >> 1);
        is_zero = (bus.In == '0);
        is_nar  = (bus.In == {1'b1, {(N-1){1'b0}}});
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            k_q     <= '0;
            exp_q   <= '0;
            mant_q  <= '0;
            rem_q   <= '0;
            nar_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                sign_q <= sign_c;
                rem_q  <= rem_c;
                nar_q  <= is_nar;
                zero_q <= is_zero;
                if (is_zero || is_nar) begin
                    k_q    <= '0;
                    exp_q  <= '0;
                    mant_q <= '0;
                end else begin
                    k_q    <= k_c;
                    exp_q  <= exp_c;
                    mant_q <= mant_c;
                end
            end
        end
    end

    assign bus.out_valid_o = valid_q;
    assign bus.Sign        = sign_q;
    assign bus.k           = k_q;
    assign bus.Exponent    = exp_q;
    assign bus.Mantissa    = mant_q;
    assign bus.InRemain    = rem_q;
    assign bus.NaR         = nar_q;
    assign bus.zero        = zero_q;

endmodule

// File: tb/tb_posit_field_extract.sv
// Bench for posit_field_extract: directed vector table, hold/reset sequences,
// and random words checked against a bit-walking posit reference model.
module tb_posit_field_extract;

    localparam int N  = 32;
    localparam int ES = 2;
    localparam int RS = $clog2(N);
    localparam int KW = RS + 1;
    localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

    typedef struct packed {
        logic                valid;
        logic                sign;
        logic signed [KW-1:0] k;
        logic [ES-1:0]       exponent;
        logic [N-1:0]        mant;
        logic [N-2:0]        rem;
        logic                nar;
        logic                zero;
    } dec_t;

    typedef struct {
        logic [N-1:0] word;
        dec_t         want;
    } vec_t;

    logic clk;
    logic rst_n;
    int   assertions;
    int   failures;

    posit_field_extract_if #(.N(N), .ES(ES)) bus ();

    posit_field_extract #(.N(N), .ES(ES)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish, required finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    function automatic dec_t mk(logic s, int kv, logic [ES-1:0] e, logic [N-1:0] m,
                                logic [N-2:0] r, logic nar, logic z);
        dec_t d;
        d.valid    = 1'b1;
        d.sign     = s;
        d.k        = KW'(kv);
        d.exponent = e;
        d.mant     = m;
        d.rem      = r;
        d.nar      = nar;
        d.zero     = z;
        return d;
    endfunction

    // Reads the posit as a bit string: regime run, terminator, exponent, fraction.
    function automatic dec_t refModel(logic [N-1:0] w);
        dec_t         d;
        logic [N-1:0] mag;
        logic         r0;
        int           pos;
        int           run;
        int           dst;
        d      = '0;
        d.valid = 1'b1;
        d.sign = w[N-1];
        if (w == '0) begin
            d.zero = 1'b1;
            return d;
        end
        if (w == NAR_WORD) begin
            d.nar = 1'b1;
            return d;
        end
        mag   = d.sign ? (~w + 1'b1) : w;
        d.rem = mag[N-2:0];
        pos   = N - 2;
        r0    = mag[pos];
        run   = 0;
        while (pos >= 0 && mag[pos] == r0) begin
            run++;
            pos--;
        end
        d.k = KW'(r0 ? run - 1 : -run);
        pos--;
        for (int e = 0; e < ES; e++) begin
            d.exponent[ES-1-e] = (pos >= 0) ? mag[pos] : 1'b0;
            pos--;
        end
        d.mant[N-1] = 1'b1;
        dst = N - 2;
        while (pos >= 0) begin
            d.mant[dst] = mag[pos];
            dst--;
            pos--;
        end
        return d;
    endfunction

    function automatic dec_t sampleDut();
        dec_t d;
        d.valid    = bus.out_valid_o;
        d.sign     = bus.Sign;
        d.k        = bus.k;
        d.exponent = bus.Exponent;
        d.mant     = bus.Mantissa;
        d.rem      = bus.InRemain;
        d.nar      = bus.NaR;
        d.zero     = bus.zero;
        return d;
    endfunction

    task automatic applyStimulus(input logic valid, input logic [N-1:0] word, input logic rstn);
        @(negedge clk);
        rst_n          = rstn;
        bus.in_valid_i = valid;
        bus.In         = word;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input dec_t want);
        dec_t got;
        got = sampleDut();
        assertions++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got v=%0b s=%0b k=%0d e=%b m=%h r=%h nar=%0b z=%0b, expected v=%0b s=%0b k=%0d e=%b m=%h r=%h nar=%0b z=%0b",
                     name, got.valid, got.sign, got.k, got.exponent, got.mant, got.rem, got.nar, got.zero,
                     want.valid, want.sign, want.k, want.exponent, want.mant, want.rem, want.nar, want.zero);
        end
    endtask

    initial begin
        vec_t          vecs[9];
        dec_t          held;
        dec_t          cleared;
        logic [N-1:0]  w;
        logic          v;

        assertions = 0;
        failures   = 0;
        cleared    = '0;

        vecs[0] = '{word: 32'h00000000, want: mk(1'b0,   0, 2'b00, 32'h00000000, 31'h00000000, 1'b0, 1'b1)};
        vecs[1] = '{word: 32'h40000000, want: mk(1'b0,   0, 2'b00, 32'h80000000, 31'h40000000, 1'b0, 1'b0)};
        vecs[2] = '{word: 32'hFFFFFFFF, want: mk(1'b1, -30, 2'b00, 32'h80000000, 31'h00000001, 1'b0, 1'b0)};
        vecs[3] = '{word: 32'h68008840, want: mk(1'b0,   1, 2'b10, 32'h80110800, 31'h68008840, 1'b0, 1'b0)};
        vecs[4] = '{word: 32'h7FFFFFFF, want: mk(1'b0,  30, 2'b00, 32'h80000000, 31'h7FFFFFFF, 1'b0, 1'b0)};
        vecs[5] = '{word: 32'hC0000000, want: mk(1'b1,   0, 2'b00, 32'h80000000, 31'h40000000, 1'b0, 1'b0)};
        vecs[6] = '{word: 32'h00000001, want: mk(1'b0, -30, 2'b00, 32'h80000000, 31'h00000001, 1'b0, 1'b0)};
        vecs[7] = '{word: 32'h50000000, want: mk(1'b0,   0, 2'b10, 32'h80000000, 31'h50000000, 1'b0, 1'b0)};
        vecs[8] = '{word: 32'h80000000, want: mk(1'b1,   0, 2'b00, 32'h00000000, 31'h00000000, 1'b1, 1'b0)};

        rst_n          = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.In         = '0;

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h40000000, 1'b0);
            checkOutput("reset", cleared);
        end

        // Back-to-back valid words, each checked one cycle after it is presented.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].word, 1'b1);
            checkOutput($sformatf("vec%0d_%h", i, vecs[i].word), vecs[i].want);
        end

        held       = vecs[8].want;
        held.valid = 1'b0;
        applyStimulus(1'b0, 32'h12345678, 1'b1);
        checkOutput("hold_after_nar", held);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: w = N'($urandom);
                1: w = N'($urandom) >> $urandom_range(0, N-1);
                2: w = ~(N'($urandom) >> $urandom_range(0, N-1));
                default: begin
                    case ($urandom_range(0, 5))
                        0: w = '0;
                        1: w = NAR_WORD;
                        2: w = 32'h7FFFFFFF;
                        3: w = 32'h00000001;
                        4: w = 32'hFFFFFFFF;
                        default: w = 32'h80000001;
                    endcase
                end
            endcase
            v = ($urandom_range(0, 3) != 0);
            applyStimulus(v, w, 1'b1);
            if (v) begin
                held = refModel(w);
            end else begin
                held.valid = 1'b0;
            end
            checkOutput($sformatf("rand%0d_%h_v%0b", i, w, v), held);
        end

        applyStimulus(1'b1, 32'h68008840, 1'b1);
        checkOutput("pre_reset_load", vecs[3].want);
        applyStimulus(1'b1, 32'h40000000, 1'b0);
        checkOutput("reset_wins", cleared);
        applyStimulus(1'b0, 32'h40000000, 1'b1);
        checkOutput("reset_drop_input", cleared);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
